regfile_mp: RTL and testbench

Parametrised, two-write-port register file for the single-cycle MIPS datapath and its pipelined follow-on. It provides two asynchronous read ports with optional same-cycle write bypass, and an optional hardwired zero register. Port A carries ALU writeback and port B carries multi-cycle load writeback. A per-register pending-load scoreboard lets decode logic detect reads of registers whose load has not yet returned.

---
 rtl/regfile_mp.sv | 105 ++++++++++
 tb/tb_regfile_mp.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Two-write-port register file with async read ports, optional same-cycle write bypass,
// optional hardwired zero register and a per-register pending-load scoreboard.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 2**ADDR_W,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              busy1,
  output logic              busy2,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] wa_a,
  input  logic [DATA_W-1:0] wd_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] wa_b,
  input  logic [DATA_W-1:0] wd_b,
  input  logic              busy_set,
  input  logic [ADDR_W-1:0] busy_addr,
  output logic              collide
);

  localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W+1)'(NUM_REGS);

  // True for addresses that name real, writable storage (excludes r0 when hardwired).
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < NUM_REGS_L) && !(ZERO_REG && (a == '0));
  endfunction

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                collide_q, collide_d;

  logic wr_a_ok, wr_b_ok, set_ok;

  assign wr_a_ok = we_a     && addr_ok(wa_a);
  assign wr_b_ok = we_b     && addr_ok(wa_b);
  assign set_ok  = busy_set && addr_ok(busy_addr);

  // Port B applied first so port A overrides on equal addresses; likewise a
  // busy_set lands after the load-return clear so a new issue keeps the bit.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_b_ok) begin
      regs_d[wa_b] = wd_b;
      busy_d[wa_b] = 1'b0;
    end
    if (wr_a_ok) regs_d[wa_a] = wd_a;
    if (set_ok)  busy_d[busy_addr] = 1'b1;
    collide_d = we_a && we_b && (wa_a == wa_b);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      busy_q    <= '0;
      collide_q <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      busy_q    <= busy_d;
      collide_q <= collide_d;
    end
  end

  logic [ADDR_W-1:0] ra   [2];
  logic [DATA_W-1:0] rd   [2];
  logic              bz   [2];

  assign ra[0] = ra1;
  assign ra[1] = ra2;

  // Read outputs are forced to zero while reset is held, even if a write is presented.
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      rd[p] = '0;
      bz[p] = 1'b0;
      if (rst && addr_ok(ra[p])) begin
        rd[p] = regs_q[ra[p]];
        bz[p] = busy_q[ra[p]];
        if (BYPASS) begin
          if (we_b && (wa_b == ra[p])) begin
            rd[p] = wd_b;
            bz[p] = 1'b0;
          end
          if (we_a && (wa_a == ra[p])) rd[p] = wd_a;
        end
      end
    end
  end

  assign rd1     = rd[0];
  assign rd2     = rd[1];
  assign busy1   = bz[0];
  assign busy2   = bz[1];
  assign collide = collide_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one default instance driven from a vector table, plus
// variant instances (no bypass, no zero register, 24 registers) checked in hand sequences.
module tb_regfile_mp;

  logic        clk;
  logic        rst;
  logic [4:0]  ra1, ra2, wa_a, wa_b, busy_addr;
  logic [31:0] wd_a, wd_b;
  logic        we_a, we_b, busy_set;

  logic [31:0] rd1_w [4];
  logic [31:0] rd2_w [4];
  logic        b1_w  [4];
  logic        b2_w  [4];
  logic        col_w [4];

  int n_total = 0;
  int n_pass  = 0;

  regfile_mp u0 (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_w[0]), .rd2(rd2_w[0]),
    .busy1(b1_w[0]), .busy2(b2_w[0]), .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b), .busy_set(busy_set), .busy_addr(busy_addr),
    .collide(col_w[0]));

  regfile_mp #(.BYPASS(1'b0)) u1 (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_w[1]), .rd2(rd2_w[1]),
    .busy1(b1_w[1]), .busy2(b2_w[1]), .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b), .busy_set(busy_set), .busy_addr(busy_addr),
    .collide(col_w[1]));

  regfile_mp #(.ZERO_REG(1'b0)) u2 (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_w[2]), .rd2(rd2_w[2]),
    .busy1(b1_w[2]), .busy2(b2_w[2]), .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b), .busy_set(busy_set), .busy_addr(busy_addr),
    .collide(col_w[2]));

  regfile_mp #(.NUM_REGS(24)) u3 (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_w[3]), .rd2(rd2_w[3]),
    .busy1(b1_w[3]), .busy2(b2_w[3]), .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b), .busy_set(busy_set), .busy_addr(busy_addr),
    .collide(col_w[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we_a;
    logic [4:0]  wa_a;
    logic [31:0] wd_a;
    logic        we_b;
    logic [4:0]  wa_b;
    logic [31:0] wd_b;
    logic        bs;
    logic [4:0]  ba;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic        e_b1;
    logic        e_b2;
    logic        e_col;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t mk(
    input logic wea, input logic [4:0] waa, input logic [31:0] wda,
    input logic web, input logic [4:0] wab, input logic [31:0] wdb,
    input logic bs, input logic [4:0] ba, input logic [4:0] r1, input logic [4:0] r2,
    input logic [31:0] erd1, input logic [31:0] erd2,
    input logic eb1, input logic eb2, input logic ecol);
    vec_t v;
    v.we_a = wea; v.wa_a = waa; v.wd_a = wda;
    v.we_b = web; v.wa_b = wab; v.wd_b = wdb;
    v.bs = bs; v.ba = ba; v.ra1 = r1; v.ra2 = r2;
    v.e_rd1 = erd1; v.e_rd2 = erd2; v.e_b1 = eb1; v.e_b2 = eb2; v.e_col = ecol;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    we_a = v.we_a; wa_a = v.wa_a; wd_a = v.wd_a;
    we_b = v.we_b; wa_b = v.wa_b; wd_b = v.wd_b;
    busy_set = v.bs; busy_addr = v.ba;
    ra1 = v.ra1; ra2 = v.ra2;
  endtask

  task automatic drive(
    input logic wea, input logic [4:0] waa, input logic [31:0] wda,
    input logic web, input logic [4:0] wab, input logic [31:0] wdb,
    input logic bs, input logic [4:0] ba, input logic [4:0] r1, input logic [4:0] r2);
    apply(mk(wea, waa, wda, web, wab, wdb, bs, ba, r1, r2, '0, '0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  initial begin
    // Starting from all-zero state; each row is one cycle, checked before its rising edge.
    tbl[0]  = mk(1, 3, 32'h1234,     0, 0, 0,     0, 0, 3, 3, 32'h1234, 32'h1234, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0,            0, 0, 0,     0, 0, 3, 0, 32'h1234, 0,        0, 0, 0);
    tbl[2]  = mk(1, 9, 32'hA,        1, 9, 32'hB, 0, 0, 9, 3, 32'hA,    32'h1234, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0,            0, 0, 0,     0, 0, 9, 9, 32'hA,    32'hA,    0, 0, 1);
    tbl[4]  = mk(0, 0, 0,            0, 0, 0,     0, 0, 9, 3, 32'hA,    32'h1234, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0,            0, 0, 0,     1, 4, 4, 4, 0,        0,        0, 0, 0);
    tbl[6]  = mk(0, 0, 0,            0, 0, 0,     0, 0, 4, 4, 0,        0,        1, 1, 0);
    tbl[7]  = mk(0, 0, 0,            1, 4, 32'h55,0, 0, 4, 4, 32'h55,   32'h55,   0, 0, 0);
    tbl[8]  = mk(0, 0, 0,            0, 0, 0,     0, 0, 4, 3, 32'h55,   32'h1234, 0, 0, 0);
    tbl[9]  = mk(0, 0, 0,            1, 4, 32'h66,1, 4, 4, 4, 32'h66,   32'h66,   0, 0, 0);
    tbl[10] = mk(0, 0, 0,            0, 0, 0,     0, 0, 4, 4, 32'h66,   32'h66,   1, 1, 0);
    tbl[11] = mk(0, 0, 0,            0, 0, 0,     1, 4, 4, 4, 32'h66,   32'h66,   1, 1, 0);
    tbl[12] = mk(0, 0, 0,            0, 0, 0,     0, 0, 4, 4, 32'h66,   32'h66,   1, 1, 0);
    tbl[13] = mk(1, 0, 32'hFFFFFFFF, 0, 0, 0,     1, 0, 0, 4, 0,        32'h66,   0, 1, 0);
    tbl[14] = mk(0, 0, 0,            0, 0, 0,     0, 0, 0, 4, 0,        32'h66,   0, 1, 0);
    tbl[15] = mk(1, 0, 32'h1,        1, 0, 32'h2, 0, 0, 0, 0, 0,        0,        0, 0, 0);
    tbl[16] = mk(0, 0, 0,            0, 0, 0,     0, 0, 0, 0, 0,        0,        0, 0, 1);
    tbl[17] = mk(1, 5, 32'hDEADBEEF, 1, 6, 32'h77,0, 0, 5, 6, 32'hDEADBEEF, 32'h77, 0, 0, 0);
    tbl[18] = mk(0, 0, 0,            0, 0, 0,     1, 7, 5, 6, 32'hDEADBEEF, 32'h77, 0, 0, 0);
    tbl[19] = mk(1, 4, 32'h99,       1, 4, 32'h88,0, 0, 4, 7, 32'h99,   0,        0, 1, 0);
    tbl[20] = mk(0, 0, 0,            0, 0, 0,     0, 0, 4, 7, 32'h99,   0,        0, 1, 1);

    rst = 1'b0;
    drive(1, 3, 32'h5A5A, 0, 0, 0, 1, 3, 3, 3);
    #1;
    chk("reset rd1", rd1_w[0], 32'h0);
    chk("reset busy1", {31'b0, b1_w[0]}, 32'h0);
    chk("reset collide", {31'b0, col_w[0]}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 3, 3);
    rst = 1'b1;
    #1;
    chk("post-reset rd1 write lost", rd1_w[0], 32'h0);
    chk("post-reset busy1 set lost", {31'b0, b1_w[0]}, 32'h0);

    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      apply(tbl[i]);
      #1;
      chk($sformatf("row%0d rd1", i), rd1_w[0], tbl[i].e_rd1);
      chk($sformatf("row%0d rd2", i), rd2_w[0], tbl[i].e_rd2);
      chk($sformatf("row%0d busy1", i), {31'b0, b1_w[0]}, {31'b0, tbl[i].e_b1});
      chk($sformatf("row%0d busy2", i), {31'b0, b2_w[0]}, {31'b0, tbl[i].e_b2});
      chk($sformatf("row%0d collide", i), {31'b0, col_w[0]}, {31'b0, tbl[i].e_col});
    end

    // Mid-run async reset with r5 written, r7 busy and a collision pulse live.
    @(negedge clk);
    drive(1, 9, 32'h1, 1, 9, 32'h2, 0, 0, 5, 7);
    #1;
    chk("pre-rst rd1 r5", rd1_w[0], 32'hDEADBEEF);
    chk("pre-rst busy2 r7", {31'b0, b2_w[0]}, 32'h1);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 5, 7);
    chk("pre-rst collide", {31'b0, col_w[0]}, 32'h1);
    rst = 1'b0;
    #1;
    chk("mid-rst rd1 r5", rd1_w[0], 32'h0);
    chk("mid-rst busy2 r7", {31'b0, b2_w[0]}, 32'h0);
    chk("mid-rst collide", {31'b0, col_w[0]}, 32'h0);
    drive(1, 5, 32'h11, 0, 0, 0, 1, 5, 5, 9);
    @(posedge clk);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 5, 9);
    rst = 1'b1;
    #1;
    chk("rst-write lost r5", rd1_w[0], 32'h0);
    chk("rst-set lost r5", {31'b0, b1_w[0]}, 32'h0);
    chk("rst cleared r9", rd2_w[0], 32'h0);

    // No-bypass variant: write visible one cycle later, busy not masked by load return.
    @(negedge clk);
    drive(1, 3, 32'h1234, 0, 0, 0, 0, 0, 3, 4);
    #1;
    chk("byp rd1 same cycle", rd1_w[0], 32'h1234);
    chk("nobyp rd1 old value", rd1_w[1], 32'h0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 1, 4, 3, 4);
    #1;
    chk("nobyp rd1 next cycle", rd1_w[1], 32'h1234);
    @(negedge clk);
    drive(0, 0, 0, 1, 4, 32'h55, 0, 0, 4, 3);
    #1;
    chk("nobyp busy1 during return", {31'b0, b1_w[1]}, 32'h1);
    chk("nobyp rd1 during return", rd1_w[1], 32'h0);
    chk("byp busy1 during return", {31'b0, b1_w[0]}, 32'h0);
    chk("byp rd1 during return", rd1_w[0], 32'h55);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 4, 3);
    #1;
    chk("nobyp busy1 after return", {31'b0, b1_w[1]}, 32'h0);
    chk("nobyp rd1 after return", rd1_w[1], 32'h55);

    // Zero register present vs absent.
    @(negedge clk);
    drive(1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 0, 3);
    #1;
    chk("zero rd1 r0", rd1_w[0], 32'h0);
    chk("nozero rd1 r0 bypass", rd1_w[2], 32'hFFFFFFFF);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    #1;
    chk("zero rd1 r0 after", rd1_w[0], 32'h0);
    chk("zero busy1 r0 after", {31'b0, b1_w[0]}, 32'h0);
    chk("nozero rd1 r0 after", rd1_w[2], 32'hFFFFFFFF);
    chk("nozero busy1 r0 after", {31'b0, b1_w[2]}, 32'h1);

    // 24-register variant: r30 and r24 are out of range, r23 is the last real register.
    @(negedge clk);
    drive(1, 30, 32'h30, 0, 0, 0, 1, 30, 30, 3);
    #1;
    chk("n24 rd1 r30 bypass", rd1_w[3], 32'h0);
    chk("n24 busy1 r30", {31'b0, b1_w[3]}, 32'h0);
    chk("n32 rd1 r30 bypass", rd1_w[0], 32'h30);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 30, 3);
    #1;
    chk("n24 rd1 r30 after", rd1_w[3], 32'h0);
    chk("n24 busy1 r30 after", {31'b0, b1_w[3]}, 32'h0);
    chk("n24 rd2 r3 intact", rd2_w[3], 32'h1234);
    chk("n32 rd1 r30 after", rd1_w[0], 32'h30);
    chk("n32 busy1 r30 after", {31'b0, b1_w[0]}, 32'h1);
    @(negedge clk);
    drive(1, 23, 32'h23, 1, 24, 32'h24, 0, 0, 23, 24);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 23, 24);
    #1;
    chk("n24 rd1 r23", rd1_w[3], 32'h23);
    chk("n24 rd2 r24", rd2_w[3], 32'h0);
    chk("n32 rd2 r24", rd2_w[0], 32'h24);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
